vga_pixel_source: RTL and testbench
===================================

VGA_PIXEL_SOURCE -- requirements
Module: vga_pixel_source

Interface
REQ-001 The module SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 clk  input  1  pixel clock, shared with the downstream VGA timing block.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 iCtrH, iCtrV  input  19 each  horizontal/vertical pixel counters driven by the VGA block's oCtrH/oCtrV.
REQ-005 iWrValid  input  1  cell-write request.
REQ-006 iWrX  input  7  cell column, 0..79.
REQ-007 iWrY  input  6  cell row, 0..59.
REQ-008 iWrColor  input  3  cell RGB, one bit per channel.
REQ-009 oWrReady  output  1  write accepted when iWrValid and oWrReady are both high at a rising edge.
REQ-010 iClear  input  1  single-cycle pulse; fills every cell with iClrColor.
REQ-011 iClrColor  input  3  fill color for clear.
REQ-012 oData  output  3  pixel color to the VGA block's data input.

Function
REQ-013 Frame store SHALL hold 80x60 cells of 3 bits; each cell covers 8x8 pixels of the 640x480 active area.
REQ-014 Cell address SHALL be y*80+x, 13 bits, computed as (y<<6)+(y<<4)+x with no multiplier.
REQ-015 Read cell SHALL be (iCtrH>>3, iCtrV>>3); oData SHALL be valid exactly 2 clk cycles after the counter values are presented.
REQ-016 The read pipeline SHALL drive oData to 3'b000 when iCtrH>=640 or iCtrV>=480; this visible flag travels with the address.
REQ-017 Accepted writes with iWrX>=80 or iWrY>=60 SHALL be consumed and discarded, leaving memory unchanged.
REQ-018 A write accepted at edge N SHALL be visible to reads whose address is registered at edge N+1 or later; a same-cycle read returns old data.
REQ-019 The FSM SHALL have two states, IDLE and CLEAR; oWrReady SHALL be high only in IDLE.
REQ-020 IDLE->CLEAR SHALL occur on iClear; CLEAR SHALL write iClrColor (sampled at entry) to addresses 0..4799, one per cycle, then return to IDLE, taking 4800 cycles.
REQ-021 iClear asserted during CLEAR SHALL restart the sweep at address 0 with the newly sampled color.
REQ-022 iClear and iWrValid high in the same IDLE cycle SHALL start the clear; the write SHALL NOT be accepted and must be held by the producer.
REQ-023 Reads SHALL continue uninterrupted during CLEAR.

Reset
REQ-024 While rst is low: FSM=CLEAR, clear address=0, clear color=3'b000, oWrReady=0, oData=3'b000, pipeline registers cleared.
REQ-025 After reset release, an automatic black clear SHALL run; oWrReady SHALL rise 4800 cycles later.
REQ-026 Reset asserted mid-clear SHALL abort the sweep; the sweep restarts from address 0 on release.
REQ-027 Frame-store contents SHALL have no reset; they are defined only by clears and writes.

Configuration
REQ-028 With VGA_PIXEL_SOURCE_CURSOR_EN defined, inputs iCursorX[6:0] and iCursorY[5:0] SHALL exist, and the matching cell's color SHALL be bitwise inverted while the blink bit is 1.
REQ-029 The blink bit SHALL toggle every 32 frames.
REQ-030 A frame SHALL be counted when iCtrV changes from nonzero to 0; the frame counter and blink bit SHALL reset to 0.
REQ-031 Without VGA_PIXEL_SOURCE_CURSOR_EN, the cursor ports, frame counter and inversion logic SHALL be absent, and oData SHALL be the raw cell color.

Structure
REQ-032 Shared package vga_pkg SHALL hold H_ACTIVE=640, V_ACTIVE=480, CELL_SHIFT=3, COLS=80, ROWS=60, DEPTH=4800 and the FSM state encoding.
REQ-033 Storage SHALL be the sub-module vga_cell_ram: simple dual-port, 4800x3, with a synchronous write port and a registered read port.

Verification
REQ-034 Reset-release scenario: hold rst low for 10 cycles, then release -> oWrReady=0 for 4800 cycles then 1; all reads return 000.
REQ-035 Pixel-latency scenario: write (x=5, y=2, color=3'b101), then present iCtrH=40, iCtrV=16 -> oData=101 two cycles later; iCtrH=48 -> 000.
REQ-036 Blanking scenario: fill all cells with 111, then present iCtrH=640 or iCtrV=480 -> oData=000 two cycles later.
REQ-037 Boundary scenario: write x=79, y=59 color 010 -> pixel (639,479) reads 010; write x=80 -> accepted with no memory change.
REQ-038 Collision scenario: iClear with iClrColor=011 in the same cycle as iWrValid -> oWrReady drops; after 4800 cycles every cell reads 011; the held write then lands.
REQ-039 Cursor scenario (with VGA_PIXEL_SOURCE_CURSOR_EN): cursor at (0,0) on cell 001, run 32 frames -> pixel (0,0) reads 110, then 001 after a further 32 frames.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared geometry constants, FSM encoding and cell address helper
package vga_pkg;

  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int CELL_SHIFT = 3;
  localparam int COLS       = 80;
  localparam int ROWS       = 60;
  localparam int DEPTH      = 4800;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } pixStateT;

  // y*80 + x built from shifts so no multiplier is inferred
  function automatic logic [12:0] cellAddr(input logic [5:0] y, input logic [6:0] x);
    return ({7'd0, y} << 6) + ({7'd0, y} << 4) + {6'd0, x};
  endfunction

endpackage

// File: rtl/vga_cell_ram.sv
// rtl/vga_cell_ram.sv - 4800x3 simple dual-port frame store, sync write, registered read
module vga_cell_ram
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        iWe,
  input  logic [12:0] iWrAddr,
  input  logic [2:0]  iWrData,
  input  logic [12:0] iRdAddr,
  output logic [2:0]  oRdData
);

  logic [2:0] mem [0:DEPTH-1];

  // contents deliberately unreset; a read racing a write to the same cell sees old data
  always_ff @(posedge clk) begin
    if (iWe) mem[iWrAddr] <= iWrData;
    oRdData <= mem[iRdAddr];
  end

endmodule

// File: rtl/vga_pixel_source.sv
// rtl/vga_pixel_source.sv - 80x60 cell frame store feeding a VGA timing block
// Optional blinking cursor enabled by defining VGA_PIXEL_SOURCE_CURSOR_EN.
module vga_pixel_source
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [18:0] iCtrH,
  input  logic [18:0] iCtrV,
  input  logic        iWrValid,
  input  logic [6:0]  iWrX,
  input  logic [5:0]  iWrY,
  input  logic [2:0]  iWrColor,
  output logic        oWrReady,
  input  logic        iClear,
  input  logic [2:0]  iClrColor,
`ifdef VGA_PIXEL_SOURCE_CURSOR_EN
  input  logic [6:0]  iCursorX,
  input  logic [5:0]  iCursorY,
`endif
  output logic [2:0]  oData
);

  pixStateT    state, stateNext;
  logic [12:0] clrAddr, clrAddrNext;
  logic [2:0]  clrColor, clrColorNext;
  logic        ramWe;
  logic [12:0] ramWrAddr;
  logic [2:0]  ramWrData;
  logic        wrInRange;

  assign wrInRange = (iWrX < 7'(COLS)) && (iWrY < 6'(ROWS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= CLEAR;
      clrAddr  <= '0;
      clrColor <= '0;
    end else begin
      state    <= stateNext;
      clrAddr  <= clrAddrNext;
      clrColor <= clrColorNext;
    end
  end

  // ready is withdrawn while iClear is up so a colliding write stays with the producer
  always_comb begin
    stateNext    = state;
    clrAddrNext  = clrAddr;
    clrColorNext = clrColor;
    ramWe        = 1'b0;
    ramWrAddr    = cellAddr(iWrY, iWrX);
    ramWrData    = iWrColor;
    oWrReady     = 1'b0;
    case (state)
      IDLE: begin
        oWrReady = !iClear;
        if (iClear) begin
          stateNext    = CLEAR;
          clrAddrNext  = '0;
          clrColorNext = iClrColor;
        end else if (iWrValid && wrInRange) begin
          ramWe = 1'b1;
        end
      end
      CLEAR: begin
        if (iClear) begin
          clrAddrNext  = '0;
          clrColorNext = iClrColor;
        end else begin
          ramWe     = 1'b1;
          ramWrAddr = clrAddr;
          ramWrData = clrColor;
          if (clrAddr == 13'(DEPTH - 1)) stateNext = IDLE;
          else clrAddrNext = clrAddr + 13'd1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  logic        visible, vis1, vis2;
  logic [12:0] rdAddrNext, rdAddr;
  logic [2:0]  ramRdData;
  logic [2:0]  invMask;

  assign visible    = (iCtrH < 19'(H_ACTIVE)) && (iCtrV < 19'(V_ACTIVE));
  assign rdAddrNext = visible ? cellAddr(iCtrV[CELL_SHIFT +: 6], iCtrH[CELL_SHIFT +: 7]) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdAddr <= '0;
      vis1   <= 1'b0;
      vis2   <= 1'b0;
    end else begin
      rdAddr <= rdAddrNext;
      vis1   <= visible;
      vis2   <= vis1;
    end
  end

  vga_cell_ram uRam (
    .clk     (clk),
    .iWe     (ramWe),
    .iWrAddr (ramWrAddr),
    .iWrData (ramWrData),
    .iRdAddr (rdAddr),
    .oRdData (ramRdData)
  );

`ifdef VGA_PIXEL_SOURCE_CURSOR_EN
  logic [18:0] prevV;
  logic [4:0]  frameCnt;
  logic        blink, cur1, cur2;

  // a frame ends when the vertical counter wraps back to zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prevV    <= '0;
      frameCnt <= '0;
      blink    <= 1'b0;
      cur1     <= 1'b0;
      cur2     <= 1'b0;
    end else begin
      prevV <= iCtrV;
      if (iCtrV == 19'd0 && prevV != 19'd0) begin
        frameCnt <= frameCnt + 5'd1;
        if (frameCnt == 5'd31) blink <= ~blink;
      end
      cur1 <= visible && (iCtrH[CELL_SHIFT +: 7] == iCursorX) && (iCtrV[CELL_SHIFT +: 6] == iCursorY);
      cur2 <= cur1;
    end
  end

  assign invMask = {3{cur2 & blink}};
`else
  assign invMask = 3'b000;
`endif

  assign oData = vis2 ? (ramRdData ^ invMask) : 3'b000;

endmodule

// File: tb/tb_vga_pixel_source.sv
// tb/tb_vga_pixel_source.sv - scoreboard bench for vga_pixel_source
module tb_vga_pixel_source;

  typedef struct {
    logic [18:0] h;
    logic [18:0] v;
    logic [2:0]  c;
  } probeT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [18:0] iCtrH = '0, iCtrV = '0;
  logic        iWrValid = 1'b0;
  logic [6:0]  iWrX = '0;
  logic [5:0]  iWrY = '0;
  logic [2:0]  iWrColor = '0;
  logic        oWrReady;
  logic        iClear = 1'b0;
  logic [2:0]  iClrColor = '0;
  logic [2:0]  oData;
`ifdef VGA_PIXEL_SOURCE_CURSOR_EN
  logic [6:0]  iCursorX = '0;
  logic [5:0]  iCursorY = '0;
`endif

  int errors = 0;
  int checks = 0;
  probeT expQ[$];
  probeT monExp;
  logic tag = 1'b0, tagD1 = 1'b0, tagD2 = 1'b0;

  always #5 clk = ~clk;

  vga_pixel_source dut (
    .clk       (clk),
    .rst       (rst),
    .iCtrH     (iCtrH),
    .iCtrV     (iCtrV),
    .iWrValid  (iWrValid),
    .iWrX      (iWrX),
    .iWrY      (iWrY),
    .iWrColor  (iWrColor),
    .oWrReady  (oWrReady),
    .iClear    (iClear),
    .iClrColor (iClrColor),
`ifdef VGA_PIXEL_SOURCE_CURSOR_EN
    .iCursorX  (iCursorX),
    .iCursorY  (iCursorY),
`endif
    .oData     (oData)
  );

  always @(posedge clk) begin
    tagD1 <= tag;
    tagD2 <= tagD1;
  end

  // monitor: a probe issued two edges ago is now on oData
  always @(negedge clk) begin
    if (tagD2) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL pixel: oData=%b but no expected entry queued", oData);
      end else begin
        monExp = expQ.pop_front();
        if (oData !== monExp.c) begin
          errors++;
          $display("FAIL pixel(%0d,%0d): oData=%b expected %b", monExp.h, monExp.v, oData, monExp.c);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // all stimulus tasks are entered and left 1 time unit after a rising edge
  task automatic probe(input int h, input int v, input logic [2:0] c);
    probeT p;
    p.h = 19'(h);
    p.v = 19'(v);
    p.c = c;
    iCtrH = 19'(h);
    iCtrV = 19'(v);
    tag = 1'b1;
    expQ.push_back(p);
    @(posedge clk);
    #1 tag = 1'b0;
  endtask

  task automatic doWrite(input int x, input int y, input logic [2:0] c);
    int n;
    n = 0;
    iWrX = 7'(x);
    iWrY = 6'(y);
    iWrColor = c;
    iWrValid = 1'b1;
    @(negedge clk);
    while (!oWrReady && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("write_ready(%0d,%0d)", x, y), int'(oWrReady), 1);
    @(posedge clk);
    #1 iWrValid = 1'b0;
  endtask

  task automatic waitReady(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!oWrReady && n < 6000);
    check({name, "_ready_cycles"}, n, 4800);
    @(posedge clk);
    #1;
  endtask

  task automatic doClear(input logic [2:0] c, input string name);
    iClear = 1'b1;
    iClrColor = c;
    @(posedge clk);
    #1 iClear = 1'b0;
    waitReady(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // reset release and automatic black clear
    repeat (10) @(posedge clk);
    #1;
    check("reset_ready", int'(oWrReady), 0);
    check("reset_data", int'(oData), 0);
    rst = 1'b1;
    waitReady("reset");
    probe(0, 0, 3'b000);
    probe(639, 479, 3'b000);
    probe(320, 240, 3'b000);

    // pixel latency and cell extent
    doWrite(5, 2, 3'b101);
    probe(40, 16, 3'b101);
    probe(48, 16, 3'b000);
    probe(47, 23, 3'b101);
    probe(39, 16, 3'b000);

    // last cell and discarded out-of-range writes
    doWrite(79, 59, 3'b010);
    doWrite(80, 0, 3'b111);
    doWrite(0, 60, 3'b111);
    probe(639, 479, 3'b010);
    probe(632, 472, 3'b010);
    probe(0, 8, 3'b000);
    probe(639, 0, 3'b000);
    probe(0, 479, 3'b000);

    // blanking over a white frame
    doClear(3'b111, "fill_white");
    probe(0, 0, 3'b111);
    probe(639, 479, 3'b111);
    probe(640, 0, 3'b000);
    probe(0, 480, 3'b000);
    probe(639, 480, 3'b000);
    probe(700, 500, 3'b000);

    // clear restarted mid-sweep with a new color
    iClear = 1'b1;
    iClrColor = 3'b010;
    @(posedge clk);
    #1 iClear = 1'b0;
    repeat (100) @(posedge clk);
    #1 iClear = 1'b1;
    iClrColor = 3'b101;
    @(posedge clk);
    #1 iClear = 1'b0;
    waitReady("restart");
    probe(0, 0, 3'b101);
    probe(639, 479, 3'b101);
    probe(320, 240, 3'b101);

    // write colliding with clear is held and lands afterwards
    iWrX = 7'd5;
    iWrY = 6'd2;
    iWrColor = 3'b100;
    iWrValid = 1'b1;
    iClear = 1'b1;
    iClrColor = 3'b011;
    @(negedge clk);
    check("collision_ready", int'(oWrReady), 0);
    @(posedge clk);
    #1 iClear = 1'b0;
    waitReady("collision");
    iWrValid = 1'b0;
    for (int y = 0; y < 60; y++)
      for (int x = 0; x < 80; x++)
        probe(x * 8 + (x + y) % 8, y * 8 + y % 8, (x == 5 && y == 2) ? 3'b100 : 3'b011);

    // reset in the middle of a sweep restarts a black clear
    iCtrH = '0;
    iCtrV = '0;
    iClear = 1'b1;
    iClrColor = 3'b110;
    @(posedge clk);
    #1 iClear = 1'b0;
    repeat (50) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midclear_reset_ready", int'(oWrReady), 0);
    check("midclear_reset_data", int'(oData), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    waitReady("reset_midclear");
    probe(0, 0, 3'b000);
    probe(639, 479, 3'b000);

`ifdef VGA_PIXEL_SOURCE_CURSOR_EN
    iCtrH = '0;
    iCtrV = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    waitReady("cursor_reset");
    iCursorX = '0;
    iCursorY = '0;
    doWrite(0, 0, 3'b001);
    doWrite(1, 0, 3'b001);
    probe(0, 0, 3'b001);
    for (int f = 0; f < 32; f++) begin
      iCtrV = 19'd1;
      @(posedge clk);
      #1 iCtrV = 19'd0;
      @(posedge clk);
      #1;
    end
    probe(0, 0, 3'b110);
    probe(8, 0, 3'b001);
    for (int f = 0; f < 32; f++) begin
      iCtrV = 19'd1;
      @(posedge clk);
      #1 iCtrV = 19'd0;
      @(posedge clk);
      #1;
    end
    probe(0, 0, 3'b001);
`endif

    repeat (4) @(posedge clk);
    check("scoreboard_drained", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
